// File: rtl/wb_arb_pkg.sv
// Shared Wishbone intercon definitions: cycle-type codes, arbiter states
// and a small index-width helper.
package wb_arb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INC     = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_OWNED = 1'b1
   } arb_state_e;

   // Bits needed to hold an index in [0, n-1]; never less than one.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: searches req starting one past
// last_owner and returns a one-hot grant (all zero when nothing requests).
module wb_rr_pick
   import wb_arb_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last_owner,
   output logic [N-1:0]  gnt
);

   // First requester in rotating order last_owner+1 .. last_owner+N wins.
   always_comb begin
      logic          found;
      logic [IW-1:0] idx;
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = IW'((32'(last_owner) + i) % N);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to 1-slave Wishbone B3 arbiter for the main-RAM port.
// Round-robin grant held for the whole cyc, plus a stall watchdog that
// returns err to the owner when the slave stops responding.
module wb_mem_arbiter
   import wb_arb_pkg::*;
#(
   parameter int unsigned NUM_M   = 3,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic [NUM_M*AW-1:0]     m_adr_i,
   input  logic [NUM_M*DW-1:0]     m_dat_i,
   input  logic [NUM_M*DW/8-1:0]   m_sel_i,
   input  logic [NUM_M-1:0]        m_we_i,
   input  logic [NUM_M-1:0]        m_cyc_i,
   input  logic [NUM_M-1:0]        m_stb_i,
   input  logic [NUM_M*3-1:0]      m_cti_i,
   input  logic [NUM_M*2-1:0]      m_bte_i,
   output logic [DW-1:0]           m_dat_o,
   output logic [NUM_M-1:0]        m_ack_o,
   output logic [NUM_M-1:0]        m_err_o,
   output logic [NUM_M-1:0]        m_rty_o,
   output logic [AW-1:0]           s_adr_o,
   output logic [DW-1:0]           s_dat_o,
   output logic [DW/8-1:0]         s_sel_o,
   output logic                    s_we_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic [2:0]              s_cti_o,
   output logic [1:0]              s_bte_o,
   input  logic [DW-1:0]           s_dat_i,
   input  logic                    s_ack_i,
   input  logic                    s_err_i,
   input  logic                    s_rty_i
);

   localparam int unsigned SW = DW / 8;
   localparam int unsigned IW = idx_w(NUM_M);
   localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_FIRE = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic WD_EN = (TIMEOUT != 0);

   arb_state_e       state_q, state_d;
   logic [NUM_M-1:0] grant_q, grant_d;
   logic [IW-1:0]    last_owner_q, last_owner_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [NUM_M-1:0] pick;
   logic [IW-1:0]    owner_idx;
   logic [AW-1:0]    own_adr;
   logic [DW-1:0]    own_dat;
   logic [SW-1:0]    own_sel;
   logic             own_we, own_cyc, own_stb;
   logic [2:0]       own_cti;
   logic [1:0]       own_bte;
   logic             resp_any, wd_busy, wd_fire, wd_err;

   wb_rr_pick #(
      .N  (NUM_M),
      .IW (IW)
   ) u_pick (
      .req        (m_cyc_i),
      .last_owner (last_owner_q),
      .gnt        (pick)
   );

   // Select the owner's request signals; zero when no grant is held.
   always_comb begin
      own_adr   = '0;
      own_dat   = '0;
      own_sel   = '0;
      own_we    = 1'b0;
      own_cyc   = 1'b0;
      own_stb   = 1'b0;
      own_cti   = '0;
      own_bte   = '0;
      owner_idx = '0;
      for (int unsigned k = 0; k < NUM_M; k++) begin
         if (grant_q[k]) begin
            own_adr   = m_adr_i[k*AW +: AW];
            own_dat   = m_dat_i[k*DW +: DW];
            own_sel   = m_sel_i[k*SW +: SW];
            own_we    = m_we_i[k];
            own_cyc   = m_cyc_i[k];
            own_stb   = m_stb_i[k];
            own_cti   = m_cti_i[k*3 +: 3];
            own_bte   = m_bte_i[k*2 +: 2];
            owner_idx = IW'(k);
         end
      end
   end

   assign resp_any = s_ack_i | s_err_i | s_rty_i;
   assign wd_busy  = own_cyc & own_stb;
   // The stb squash depends only on the counter so that a slave whose
   // ack follows stb combinationally cannot form a loop through s_stb_o;
   // a response seen in that same cycle still suppresses the err.
   assign wd_fire  = WD_EN & wd_busy & (cnt_q == CNT_FIRE);
   assign wd_err   = wd_fire & ~resp_any;

   assign s_adr_o = own_adr;
   assign s_dat_o = own_dat;
   assign s_sel_o = own_sel;
   assign s_we_o  = own_we;
   assign s_cyc_o = own_cyc;
   assign s_stb_o = own_stb & ~wd_fire;
   assign s_cti_o = own_cti;
   assign s_bte_o = own_bte;

   assign m_dat_o = s_dat_i;
   assign m_ack_o = grant_q & {NUM_M{s_ack_i & own_cyc}};
   assign m_err_o = grant_q & {NUM_M{(s_err_i & own_cyc) | wd_err}};
   assign m_rty_o = grant_q & {NUM_M{s_rty_i & own_cyc}};

   // Next-state: grant on request from IDLE, release on owner cyc low,
   // and advance the stall watchdog while the owner waits.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_owner_d = last_owner_q;
      cnt_d        = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (|m_cyc_i) begin
               state_d = ST_OWNED;
               grant_d = pick;
            end
         end
         ST_OWNED: begin
            if (!own_cyc) begin
               state_d      = ST_IDLE;
               grant_d      = '0;
               last_owner_d = owner_idx;
            end else if (wd_busy && !resp_any && !wd_fire) begin
               cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // State, grant, last owner and watchdog registers.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_owner_q <= IW'(NUM_M - 1);
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against
// an owner/last-owner/stall-count model of the arbiter.
module tb_wb_mem_arbiter;
   import wb_arb_pkg::*;

   localparam int NUM_M = 3;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int SW    = DW / 8;
   localparam int TO    = 8;

   logic                  wb_clk_i, wb_rst_i;
   logic [NUM_M*AW-1:0]   m_adr_i;
   logic [NUM_M*DW-1:0]   m_dat_i;
   logic [NUM_M*SW-1:0]   m_sel_i;
   logic [NUM_M-1:0]      m_we_i, m_cyc_i, m_stb_i;
   logic [NUM_M*3-1:0]    m_cti_i;
   logic [NUM_M*2-1:0]    m_bte_i;
   logic [DW-1:0]         m_dat_o;
   logic [NUM_M-1:0]      m_ack_o, m_err_o, m_rty_o;
   logic [AW-1:0]         s_adr_o;
   logic [DW-1:0]         s_dat_o;
   logic [SW-1:0]         s_sel_o;
   logic                  s_we_o, s_cyc_o, s_stb_o;
   logic [2:0]            s_cti_o;
   logic [1:0]            s_bte_o;
   logic [DW-1:0]         s_dat_i;
   logic                  s_ack_i, s_err_i, s_rty_i;

   int n_chk;
   int n_fail;

   // Model state: current owner (-1 = none), last owner, stalled cycles.
   int mo, ml, mw;

   wb_mem_arbiter #(
      .NUM_M   (NUM_M),
      .AW      (AW),
      .DW      (DW),
      .TIMEOUT (TO)
   ) dut (
      .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
      .m_adr_i  (m_adr_i),  .m_dat_i  (m_dat_i),  .m_sel_i (m_sel_i),
      .m_we_i   (m_we_i),   .m_cyc_i  (m_cyc_i),  .m_stb_i (m_stb_i),
      .m_cti_i  (m_cti_i),  .m_bte_i  (m_bte_i),
      .m_dat_o  (m_dat_o),  .m_ack_o  (m_ack_o),  .m_err_o (m_err_o),
      .m_rty_o  (m_rty_o),
      .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o (s_sel_o),
      .s_we_o   (s_we_o),   .s_cyc_o  (s_cyc_o),  .s_stb_o (s_stb_o),
      .s_cti_o  (s_cti_o),  .s_bte_o  (s_bte_o),
      .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i (s_err_i),
      .s_rty_i  (s_rty_i)
   );

   initial begin
      wb_clk_i = 1'b0;
      forever #5 wb_clk_i = ~wb_clk_i;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not end, got running required finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs follow from who owns the slave and what it sees now;
   // afterwards the model advances to the state after the coming edge.
   task automatic model_cycle();
      logic [AW-1:0]    e_adr;
      logic [DW-1:0]    e_dat;
      logic [SW-1:0]    e_sel;
      logic             e_we, e_cyc, e_stb;
      logic [2:0]       e_cti;
      logic [1:0]       e_bte;
      logic [NUM_M-1:0] e_ack, e_err, e_rty;
      logic             ocyc, ostb, resp, fire;
      int               o, c;
      e_adr = '0; e_dat = '0; e_sel = '0; e_we = 1'b0; e_cyc = 1'b0; e_stb = 1'b0;
      e_cti = '0; e_bte = '0; e_ack = '0; e_err = '0; e_rty = '0;
      if (wb_rst_i) begin
         mo = -1; ml = NUM_M - 1; mw = 0;
      end else if (mo >= 0) begin
         o     = mo;
         ocyc  = m_cyc_i[o];
         ostb  = m_stb_i[o];
         e_adr = m_adr_i[o*AW +: AW];
         e_dat = m_dat_i[o*DW +: DW];
         e_sel = m_sel_i[o*SW +: SW];
         e_we  = m_we_i[o];
         e_cti = m_cti_i[o*3 +: 3];
         e_bte = m_bte_i[o*2 +: 2];
         resp  = s_ack_i | s_err_i | s_rty_i;
         fire  = ocyc && ostb && (mw == TO - 1);
         e_cyc = ocyc;
         e_stb = ostb && !fire;
         e_ack[o] = s_ack_i && ocyc;
         e_err[o] = (s_err_i && ocyc) || (fire && !resp);
         e_rty[o] = s_rty_i && ocyc;
         if (!ocyc) begin
            ml = o; mo = -1; mw = 0;
         end else if (ostb && !resp && !fire) begin
            mw = mw + 1;
         end else begin
            mw = 0;
         end
      end else if (m_cyc_i != '0) begin
         for (int i = 1; i <= NUM_M; i++) begin
            c = (ml + i) % NUM_M;
            if (mo < 0 && m_cyc_i[c]) mo = c;
         end
         mw = 0;
      end
      check("s_adr", 64'(s_adr_o), 64'(e_adr));
      check("s_dat", 64'(s_dat_o), 64'(e_dat));
      check("s_sel", 64'(s_sel_o), 64'(e_sel));
      check("s_we",  64'(s_we_o),  64'(e_we));
      check("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
      check("s_stb", 64'(s_stb_o), 64'(e_stb));
      check("s_cti", 64'(s_cti_o), 64'(e_cti));
      check("s_bte", 64'(s_bte_o), 64'(e_bte));
      check("m_ack", 64'(m_ack_o), 64'(e_ack));
      check("m_err", 64'(m_err_o), 64'(e_err));
      check("m_rty", 64'(m_rty_o), 64'(e_rty));
      check("m_dat", 64'(m_dat_o), 64'(s_dat_i));
   endtask

   task automatic cyc_chk();
      @(negedge wb_clk_i);
      model_cycle();
   endtask

   task automatic adv();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic clk1();
      cyc_chk();
      adv();
   endtask

   task automatic set_master(input int k, input logic cyc, input logic [31:0] adr, input logic [2:0] cti);
      m_cyc_i[k]            = cyc;
      m_stb_i[k]            = cyc;
      m_we_i[k]             = 1'b0;
      m_adr_i[k*AW +: AW]   = adr;
      m_dat_i[k*DW +: DW]   = adr ^ 32'hA5A5_A5A5;
      m_sel_i[k*SW +: SW]   = '1;
      m_cti_i[k*3 +: 3]     = cti;
      m_bte_i[k*2 +: 2]     = 2'b00;
   endtask

   task automatic idle_all();
      m_cyc_i = '0; m_stb_i = '0;
      s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      clk1();
      clk1();
   endtask

   task automatic do_reset();
      wb_rst_i = 1'b1;
      clk1();
      wb_rst_i = 1'b0;
   endtask

   task automatic drive_random(input int cyc_no);
      int unsigned ack_pct;
      ack_pct = (((cyc_no / 200) % 4) == 3) ? 0 : 50;
      for (int k = 0; k < NUM_M; k++) begin
         if (m_cyc_i[k]) begin
            if ($urandom_range(0, 9) == 0) m_cyc_i[k] = 1'b0;
         end else if ($urandom_range(0, 4) == 0) begin
            m_cyc_i[k] = 1'b1;
         end
         m_stb_i[k]          = m_cyc_i[k] && ($urandom_range(0, 3) != 0);
         m_we_i[k]           = 1'($urandom());
         m_adr_i[k*AW +: AW] = $urandom();
         m_dat_i[k*DW +: DW] = $urandom();
         m_sel_i[k*SW +: SW] = 4'($urandom());
         m_cti_i[k*3 +: 3]   = 3'($urandom());
         m_bte_i[k*2 +: 2]   = 2'($urandom());
      end
      s_dat_i = $urandom();
      s_ack_i = ($urandom_range(0, 99) < ack_pct);
      s_err_i = ($urandom_range(0, 31) == 0);
      s_rty_i = ($urandom_range(0, 31) == 0);
   endtask

   int           seq[4];
   int           nseq, prev, cur, gap, beat, a1, a2, found, first, nerr, nack;
   logic [NUM_M-1:0] acked;
   logic         ack1;

   initial begin
      n_chk = 0; n_fail = 0;
      mo = -1; ml = NUM_M - 1; mw = 0;
      m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0;
      m_cyc_i = '0; m_stb_i = '0; m_cti_i = '0; m_bte_i = '0;
      s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
      wb_rst_i = 1'b1;
      adv();

      // Reset state: slave side idle, data passes through.
      s_dat_i = 32'h1234_5678;
      cyc_chk();
      check("rst_scyc", 64'(s_cyc_o), 64'(0));
      check("rst_ack", 64'(m_ack_o), 64'(0));
      check("rst_datpass", 64'(m_dat_o), 64'(32'h1234_5678));
      adv();
      wb_rst_i = 1'b0;

      // Single classic read by master 0, slave acking at once.
      set_master(0, 1'b1, 32'h100, CTI_CLASSIC);
      s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
      cyc_chk();
      check("t1_arb_cycle_scyc", 64'(s_cyc_o), 64'(0));
      adv();
      cyc_chk();
      check("t1_adr", 64'(s_adr_o), 64'(32'h100));
      check("t1_ack", 64'(m_ack_o), 64'(3'b001));
      check("t1_dat", 64'(m_dat_o), 64'(32'hCAFE_F00D));
      adv();
      idle_all();

      // Masters 0 and 1 both request; each drops cyc for one cycle after its ack.
      do_reset();
      set_master(0, 1'b1, 32'h1000, CTI_CLASSIC);
      set_master(1, 1'b1, 32'h2000, CTI_CLASSIC);
      s_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) seq[i] = 9;
      nseq = 0; prev = -1; gap = 0;
      for (int c = 0; c < 14; c++) begin
         cyc_chk();
         if (s_cyc_o) begin
            cur = (s_adr_o == 32'h1000) ? 0 : (s_adr_o == 32'h2000) ? 1 : 9;
            if (cur != prev) begin
               if (nseq < 4) seq[nseq] = cur;
               if (prev >= 0 && nseq < 4) check("t2_bubble", 64'(gap), 64'(1));
               nseq++;
               prev = cur;
            end
            gap = 0;
         end else if (m_cyc_i[1:0] == 2'b11) begin
            gap++;
         end
         acked = m_ack_o;
         adv();
         m_cyc_i[0] = !acked[0]; m_stb_i[0] = !acked[0];
         m_cyc_i[1] = !acked[1]; m_stb_i[1] = !acked[1];
      end
      check("t2_grant0", 64'(seq[0]), 64'(0));
      check("t2_grant1", 64'(seq[1]), 64'(1));
      check("t2_grant2", 64'(seq[2]), 64'(0));
      check("t2_grant3", 64'(seq[3]), 64'(1));
      idle_all();

      // Master 1 4-beat incrementing burst while master 2 waits.
      set_master(1, 1'b1, 32'h3000, CTI_INC);
      s_ack_i = 1'b1;
      clk1();
      set_master(2, 1'b1, 32'h4000, CTI_CLASSIC);
      beat = 0; a1 = 0; a2 = 0;
      for (int c = 0; c < 20 && beat < 4; c++) begin
         cyc_chk();
         if (m_ack_o[1]) a1++;
         if (m_ack_o[2]) a2++;
         ack1 = m_ack_o[1];
         adv();
         if (ack1) begin
            beat++;
            m_adr_i[AW +: AW] = 32'h3000 + 32'(4 * beat);
            m_cti_i[3 +: 3]   = (beat == 3) ? CTI_EOB : CTI_INC;
         end
      end
      check("t3_m1_acks", 64'(a1), 64'(4));
      check("t3_m2_acks_during_burst", 64'(a2), 64'(0));
      m_cyc_i[1] = 1'b0; m_stb_i[1] = 1'b0;
      found = -1;
      for (int c = 0; c < 6; c++) begin
         cyc_chk();
         if (found < 0 && s_cyc_o && s_adr_o == 32'h4000) found = c;
         adv();
      end
      check("t3_m2_grant_delay", 64'(found), 64'(2));
      idle_all();

      // Slave never acks: err on the 8th stalled cycle, then a retry succeeds.
      set_master(0, 1'b1, 32'h500, CTI_CLASSIC);
      s_ack_i = 1'b0;
      clk1();
      first = -1; nerr = 0; nack = 0;
      for (int c = 1; c <= 12; c++) begin
         cyc_chk();
         if (m_err_o[0]) begin
            nerr++;
            if (first < 0) first = c;
         end
         if (|m_ack_o) nack++;
         adv();
      end
      check("t4_err_cycle", 64'(first), 64'(8));
      check("t4_err_count", 64'(nerr), 64'(1));
      check("t4_no_ack", 64'(nack), 64'(0));
      s_ack_i = 1'b1;
      cyc_chk();
      check("t4_retry_ack", 64'(m_ack_o), 64'(3'b001));
      adv();
      idle_all();

      // Ack on the same cycle the watchdog expires: ack wins.
      set_master(0, 1'b1, 32'h600, CTI_CLASSIC);
      s_ack_i = 1'b0;
      clk1();
      for (int c = 0; c < 7; c++) clk1();
      s_ack_i = 1'b1;
      cyc_chk();
      check("t5_ack", 64'(m_ack_o), 64'(3'b001));
      check("t5_err", 64'(m_err_o), 64'(0));
      adv();
      idle_all();

      // Asynchronous reset mid-burst, then a three-way request.
      set_master(1, 1'b1, 32'h7000, CTI_INC);
      s_ack_i = 1'b1;
      clk1(); clk1(); clk1();
      #2 wb_rst_i = 1'b1;
      #1;
      check("t6_scyc", 64'(s_cyc_o), 64'(0));
      check("t6_sstb", 64'(s_stb_o), 64'(0));
      check("t6_ack", 64'(m_ack_o), 64'(0));
      check("t6_adr", 64'(s_adr_o), 64'(0));
      cyc_chk();
      adv();
      clk1();
      wb_rst_i = 1'b0;
      set_master(0, 1'b1, 32'h8000, CTI_CLASSIC);
      set_master(1, 1'b1, 32'h8100, CTI_CLASSIC);
      set_master(2, 1'b1, 32'h8200, CTI_CLASSIC);
      s_ack_i = 1'b0;
      clk1();
      cyc_chk();
      check("t6_winner", 64'(s_adr_o), 64'(32'h8000));
      adv();
      idle_all();

      // Randomized traffic with periodic stall phases.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         drive_random(c);
         clk1();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
